// File: rtl/md_unit_pkg.sv
// Shared multiply/divide definitions: op encodings, FSM states, default latencies.
package md_defs;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } md_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_e;

    localparam int unsigned MD_MULT_CYCLES_DEF = 5;
    localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/md_unit_calc.sv
// Combinational product / quotient / remainder generator for the MD unit.
module md_calc
    import md_defs::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             div_zero
);

    logic [2*WIDTH-1:0] a_ext, b_ext, prod;
    logic               mul_signed, div_signed, is_div, neg_a, neg_b;
    logic [WIDTH-1:0]   mag_a, mag_b, dvsr, q_mag, r_mag;

    always_comb begin
        mul_signed = (op == MD_MULT);
        div_signed = (op == MD_DIV);
        is_div     = (op == MD_DIV) || (op == MD_DIVU);

        // Sign-extending to 2*WIDTH makes the low 2*WIDTH bits of an unsigned multiply the signed product.
        a_ext = {{WIDTH{mul_signed & op_a[WIDTH-1]}}, op_a};
        b_ext = {{WIDTH{mul_signed & op_b[WIDTH-1]}}, op_b};
        prod  = a_ext * b_ext;

        neg_a = div_signed & op_a[WIDTH-1];
        neg_b = div_signed & op_b[WIDTH-1];
        mag_a = neg_a ? -op_a : op_a;
        mag_b = neg_b ? -op_b : op_b;

        div_zero = is_div & (op_b == '0);
        dvsr     = (op_b == '0) ? WIDTH'(1) : mag_b;
        q_mag    = mag_a / dvsr;
        r_mag    = mag_a % dvsr;

        // MIN / -1 falls out naturally: |MIN| negated wraps back to MIN.
        if (is_div) begin
            res_lo = (neg_a ^ neg_b) ? -q_mag : q_mag;
            res_hi = neg_a ? -r_mag : r_mag;
        end else begin
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the EX stage.
module md_unit
    import md_defs::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [1:0]       md_op,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             md_stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] res_hi, res_lo;
    logic             div_zero;

    md_calc #(.WIDTH(WIDTH)) u_calc (
        .op_a     (a_q),
        .op_b     (b_q),
        .op       (op_q),
        .res_hi   (res_hi),
        .res_lo   (res_lo),
        .div_zero (div_zero)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = src_a;
                    b_d     = src_b;
                    op_d    = md_op;
                    cnt_d   = (md_op == MD_MULT || md_op == MD_MULTU) ? MULT_LOAD : DIV_LOAD;
                    state_d = RUN;
                end else begin
                    if (wr_hi) hi_d = src_a;
                    if (wr_lo) lo_d = src_a;
                end
            end
            RUN: begin
                if (cnt_q == '0) begin
                    if (!div_zero) begin
                        hi_d = res_hi;
                        lo_d = res_lo;
                    end
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign md_stall = start | busy;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Randomized + directed bench for md_unit: default-latency and single-cycle instances vs a behavioural model.
module tb_md_unit;
    import md_defs::*;

    logic        clk = 1'b0;
    logic        clr, start, wr_hi, wr_lo;
    logic [1:0]  md_op;
    logic [31:0] src_a, src_b;
    logic        busy0, stall0, busyf, stallf;
    logic [31:0] hi0, lo0, hif, lof;

    always #5 clk = ~clk;

    md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(8)) dut (
        .clk(clk), .clr(clr), .start(start), .md_op(md_op), .wr_hi(wr_hi), .wr_lo(wr_lo),
        .src_a(src_a), .src_b(src_b), .busy(busy0), .md_stall(stall0), .hi(hi0), .lo(lo0)
    );

    md_unit #(.WIDTH(32), .MULT_CYCLES(1), .DIV_CYCLES(1), .CNT_W(8)) dut_f (
        .clk(clk), .clr(clr), .start(start), .md_op(md_op), .wr_hi(wr_hi), .wr_lo(wr_lo),
        .src_a(src_a), .src_b(src_b), .busy(busyf), .md_stall(stallf), .hi(hif), .lo(lof)
    );

    int chk_cnt = 0;
    int pass_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Behavioural model: each instance is busy until edge number done_at, results land on that edge.
    longint      cyc = 0;
    longint      done_at[2] = '{0, 0};
    bit          pend_ok[2];
    logic [31:0] pend_hi[2], pend_lo[2];
    logic [31:0] m_hi[2] = '{0, 0};
    logic [31:0] m_lo[2] = '{0, 0};
    int          lat_mult[2] = '{5, 1};
    int          lat_div[2]  = '{10, 1};

    function automatic void ref_calc(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output bit ok, output logic [31:0] rh, output logic [31:0] rl);
        longint p;
        logic [63:0] pu;
        int sa, sb, q, r;
        ok = 1; rh = '0; rl = '0;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            2'd0: begin p = longint'(sa) * longint'(sb); rh = p[63:32]; rl = p[31:0]; end
            2'd1: begin pu = {32'd0, a} * {32'd0, b}; rh = pu[63:32]; rl = pu[31:0]; end
            2'd2: begin
                if (b == 0) ok = 0;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin rl = a; rh = '0; end
                else begin q = sa / sb; r = sa % sb; rl = q; rh = r; end
            end
            default: begin
                if (b == 0) ok = 0;
                else begin rl = a / b; rh = a % b; end
            end
        endcase
    endfunction

    always @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < 2; i++) begin
                done_at[i] = 0; m_hi[i] = '0; m_lo[i] = '0;
            end
        end else begin
            longint c;
            c = cyc + 1;
            for (int i = 0; i < 2; i++) begin
                if (cyc < done_at[i]) begin
                    if (c == done_at[i] && pend_ok[i]) begin m_hi[i] = pend_hi[i]; m_lo[i] = pend_lo[i]; end
                end else if (start) begin
                    ref_calc(md_op, src_a, src_b, pend_ok[i], pend_hi[i], pend_lo[i]);
                    done_at[i] = c + ((md_op < 2) ? lat_mult[i] : lat_div[i]);
                end else begin
                    if (wr_hi) m_hi[i] = src_a;
                    if (wr_lo) m_lo[i] = src_a;
                end
            end
            cyc = c;
        end
    end

    always @(posedge clk) begin
        #1;
        check("busy",      busy0,  cyc < done_at[0]);
        check("md_stall",  stall0, start | (cyc < done_at[0]));
        check("hi",        hi0,    m_hi[0]);
        check("lo",        lo0,    m_lo[0]);
        check("busy_f",    busyf,  cyc < done_at[1]);
        check("md_stall_f",stallf, start | (cyc < done_at[1]));
        check("hi_f",      hif,    m_hi[1]);
        check("lo_f",      lof,    m_lo[1]);
    end

    // mt_mode: 0 none, 1 MTHI 0xAAAA while busy, 2 MTHI alongside start
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit hold, input int mt_mode,
                         input logic [31:0] eh, input logic [31:0] el, input string tag);
        int c0, cf;
        logic [31:0] prev_hi;
        @(negedge clk);
        prev_hi = m_hi[0];
        start = 1; md_op = op; src_a = a; src_b = b; wr_lo = 0;
        wr_hi = (mt_mode == 2);
        @(negedge clk);
        wr_hi = 0;
        if (mt_mode == 2) check({tag, "_hi_dropped"}, hi0, prev_hi);
        if (hold) begin md_op = ~op; src_a = a ^ 32'h5A5A5A5A; src_b = b + 32'd7; end
        else start = 0;
        if (mt_mode == 1) begin wr_hi = 1; src_a = 32'hAAAA; end
        c0 = 0; cf = 0;
        for (int k = 0; k < 40 && (busy0 || (!hold && busyf)); k++) begin
            c0 += int'(busy0);
            cf += int'(busyf);
            @(negedge clk);
        end
        start = 0; wr_hi = 0;
        check({tag, "_done"}, busy0, 1'b0);
        check({tag, "_cycles"}, c0, (op >= 2) ? 10 : 5);
        if (!hold) check({tag, "_cycles_f"}, cf, 1);
        check({tag, "_hi"}, hi0, eh);
        check({tag, "_lo"}, lo0, el);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 8)
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return $urandom % 16;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        clr = 1; start = 0; wr_hi = 0; wr_lo = 0; md_op = 0; src_a = 0; src_b = 0;
        repeat (2) @(negedge clk);
        check("rst_hi", hi0, 32'h0);
        check("rst_lo", lo0, 32'h0);
        check("rst_busy", busy0, 1'b0);
        check("rst_stall", stall0, 1'b0);
        clr = 0;

        issue(MD_MULT,  32'hFFFFFFFF, 32'h2, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFE, "mult");
        issue(MD_MULTU, 32'hFFFFFFFF, 32'h2, 0, 0, 32'h00000001, 32'hFFFFFFFE, "multu");
        issue(MD_DIV,   32'hFFFFFFF9, 32'h2, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg");
        issue(MD_DIVU,  32'h7,        32'h2, 0, 0, 32'h1,        32'h3,        "divu");
        issue(MD_DIV,   32'h80000000, 32'hFFFFFFFF, 0, 0, 32'h0, 32'h80000000, "div_min");

        @(negedge clk); wr_hi = 1; src_a = 32'h1234;
        @(negedge clk); wr_hi = 0; wr_lo = 1; src_a = 32'h5678;
        @(negedge clk); wr_lo = 0;
        issue(MD_DIVU, 32'h99, 32'h0, 0, 0, 32'h1234, 32'h5678, "div0");

        issue(MD_MULT,  32'h3,    32'h4, 0, 1, 32'h0, 32'hC,    "mthi_busy");
        issue(MD_MULTU, 32'hAAAA, 32'h1, 0, 2, 32'h0, 32'hAAAA, "mthi_start");

        @(negedge clk); wr_hi = 1; src_a = 32'hAAAA;
        @(negedge clk); wr_hi = 0;
        check("mthi_idle", hi0, 32'hAAAA);

        issue(MD_MULT, 32'h5, 32'h6, 1, 0, 32'h0, 32'h1E, "hold_start");

        @(negedge clk); start = 1; md_op = MD_MULT; src_a = 32'h7; src_b = 32'h9;
        @(negedge clk); start = 0;
        @(negedge clk);
        #2 clr = 1;
        #1;
        check("clr_busy", busy0, 1'b0);
        check("clr_stall", stall0, 1'b0);
        check("clr_hi", hi0, 32'h0);
        check("clr_lo", lo0, 32'h0);
        @(negedge clk); clr = 0; wr_lo = 1; src_a = 32'h77;
        @(negedge clk); wr_lo = 0;
        check("clr_mtlo", lo0, 32'h77);
        check("clr_mtlo_hi", hi0, 32'h0);

        repeat (600) begin
            @(negedge clk);
            clr   = ($urandom % 97 == 0);
            start = ($urandom % 4 == 0);
            md_op = 2'($urandom);
            src_a = pick();
            src_b = pick();
            wr_hi = ($urandom % 5 == 0);
            wr_lo = ($urandom % 5 == 0);
        end
        @(negedge clk);
        clr = 0; start = 0; wr_hi = 0; wr_lo = 0;
        repeat (15) @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", pass_cnt, chk_cnt);
        $fatal(1);
    end

endmodule
